siso_shift_ctrl: RTL
====================

// Module: siso_shift_ctrl
// PURPOSE
//  Sequencer for a 4-stage serial-in/serial-out shift path. Accepts a parallel
//  word on a valid/ready handshake, shifts it out MSB-first on sout, and
//  captures sin into the same register during the same bit periods.
//  Returns the captured word on a second valid/ready port (full-duplex frame).
//  Sits between a parallel producer/consumer and a serial link or SISO chain.
// PARAMETERS
//  WIDTH  4  frame length in bits (>=2)
//  DIV    1  clock cycles per bit period (>=1); bit_tick fires once per period
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      parallel word offered
//  in_data    in   WIDTH  word to transmit, MSB first
//  in_ready   out  1      word accepted when in_valid & in_ready
//  sout       out  1      serial data out
//  sin        in   1      serial data in, sampled on bit_tick
//  bit_tick   out  1      one-cycle strobe at end of each bit period (shift edge)
//  busy       out  1      frame in progress (state SHIFT)
//  out_valid  out  1      captured word pending
//  out_data   out  WIDTH  captured word (first received bit in MSB)
//  out_ready  in   1      consumer takes word when out_valid & out_ready
//  par_err    out  1      only with PARITY_EN (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; shreg, bit/div counters, out_data=0;
//   sout=0, bit_tick=0, busy=0, out_valid=0, in_ready reflects IDLE rule.
//  States: IDLE, SHIFT.
//  IDLE: in_ready = !out_valid | out_ready (combinational). On accept:
//   shreg<=in_data, bitcnt<=0, divcnt<=0, state<=SHIFT. sout=0 in IDLE.
//  SHIFT: in_ready=0, busy=1, sout=shreg[WIDTH-1]. divcnt counts 0..DIV-1;
//   bit_tick=1 when divcnt==DIV-1 (every cycle for DIV=1). On bit_tick:
//   shreg<={shreg[WIDTH-2:0],sin}, bitcnt++, divcnt<=0.
//   Tick with bitcnt==WIDTH-1: out_data<={shreg[WIDTH-2:0],sin}, out_valid<=1,
//   state<=IDLE (same edge).
//  Latency: accept at edge 0; sout valid for cycles 1..WIDTH*DIV;
//   out_valid rises after edge WIDTH*DIV. Back-to-back frames: next accept
//   possible the cycle after return to IDLE (one idle cycle between frames).
//  out_valid cleared on out_valid & out_ready; out_data stable while pending.
//  Simultaneous out pop and in accept in IDLE: both take effect.
//  Pending unread out_valid blocks new accepts (no overwrite, no loss).
//  in_valid/in_data changes during SHIFT are ignored; out_ready while
//   out_valid=0 has no effect.
//  Reset mid-frame aborts frame: no out_valid, sout=0 immediately.
// CONFIGURATION
//  PARITY_EN defined: one extra bit period after the data bits. sout = even
//   parity (XOR) of the accepted in_data; sin sampled on that tick and compared
//   with XOR of the captured word; par_err registered with out_valid
//   (1 = mismatch), cleared with the out pop. Frame = (WIDTH+1)*DIV cycles.
//  PARITY_EN undefined: no parity period, par_err port absent.
// TESTING
//  WIDTH=4, DIV=1, sin=sout loopback, in_data=4'b1011 -> sout 1,0,1,1 cycles
//   1-4, bit_tick each cycle, out_valid cycle 5 with out_data=4'b1011.
//  DIV=3, in_data=4'b0110, sin=0 -> each bit held 3 cycles, 4 bit_ticks,
//   out_valid after 12 cycles, out_data=4'b0000.
//  out_ready=0 after frame 1, in_valid held -> in_ready=0, no second frame;
//   raise out_ready -> pop and second accept in same cycle.
//  rst_n low at bit 2 of a frame -> sout=0, busy=0, out_valid=0
//   immediately; no out_valid after release.
//  PARITY_EN, in_data=4'b0111, loopback -> parity bit 1 on cycle 5,
//   par_err=0; force sin=0 on parity bit -> par_err=1 with out_valid.

Source files
------------

// File: rtl/siso_shift_ctrl.sv
// Full-duplex SISO frame sequencer: parallel word in, MSB-first serial out/in, captured word out.
// Optional build macro PARITY_EN appends an even-parity bit period and exposes par_err.
module siso_shift_ctrl #(
    parameter int WIDTH = 4,
    parameter int DIV   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             sout,
    input  logic             sin,
    output logic             bit_tick,
    output logic             busy,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
`ifdef PARITY_EN
    ,
    output logic             par_err
`endif
);

    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BIT_W = $clog2(WIDTH + 1);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic [WIDTH-1:0] out_data_q;
    logic [BIT_W-1:0] bitcnt_q;
    logic [DIV_W-1:0] divcnt_q;
    logic             out_valid_q;
    logic             tick;
    logic             accept;
    logic             pop;

    assign busy      = (state_q == SHIFT);
    assign tick      = busy && (divcnt_q == DIV_LAST);
    assign bit_tick  = tick;
    // A pending unread word blocks the next frame unless it is popped this same cycle.
    assign in_ready  = !busy && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid_q && out_ready;
    assign shreg_d   = {shreg_q[WIDTH-2:0], sin};
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

`ifdef PARITY_EN
    localparam logic [BIT_W-1:0] PAR_BIT = BIT_W'(WIDTH);

    logic par_q;
    logic par_err_q;
    logic parity_phase;

    assign parity_phase = (bitcnt_q == PAR_BIT);
    assign sout         = busy && (parity_phase ? par_q : shreg_q[WIDTH-1]);
    assign par_err      = par_err_q;
`else
    assign sout = busy && shreg_q[WIDTH-1];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            bitcnt_q    <= '0;
            divcnt_q    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
`ifdef PARITY_EN
            par_q       <= 1'b0;
            par_err_q   <= 1'b0;
`endif
        end else begin
            if (pop) begin
                out_valid_q <= 1'b0;
`ifdef PARITY_EN
                par_err_q   <= 1'b0;
`endif
            end
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        shreg_q  <= in_data;
                        bitcnt_q <= '0;
                        divcnt_q <= '0;
                        state_q  <= SHIFT;
`ifdef PARITY_EN
                        par_q    <= ^in_data;
`endif
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        divcnt_q <= '0;
                        bitcnt_q <= bitcnt_q + BIT_W'(1);
`ifdef PARITY_EN
                        // Data bits only shift; the parity tick closes the frame.
                        if (parity_phase) begin
                            out_data_q  <= shreg_q;
                            par_err_q   <= (^shreg_q) ^ sin;
                            out_valid_q <= 1'b1;
                            state_q     <= IDLE;
                        end else begin
                            shreg_q <= shreg_d;
                        end
`else
                        shreg_q <= shreg_d;
                        if (bitcnt_q == LAST_DATA) begin
                            out_data_q  <= shreg_d;
                            out_valid_q <= 1'b1;
                            state_q     <= IDLE;
                        end
`endif
                    end else begin
                        divcnt_q <= divcnt_q + DIV_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifndef PARITY_EN
    logic unused_last;
    assign unused_last = &{1'b0, LAST_DATA};
`endif

endmodule
